wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage. Consumes the EX/WB pipeline buffer outputs and commits results to a 64-entry register file.
- Resolves branches and jumps from the flag bits carried through the buffer, then issues a registered PC redirect.
- Squashes in-flight wrong-path instructions for a fixed number of cycles after a taken redirect.
- Also provides the two combinational register read ports used by the decode stage.

Parameters:
- DATA_W, 33: data width; matches the EX/WB buffer memdata/aluresult width.
- NREGS, 64: register count; address width is 6.
- FLUSH_CYCLES, 3: number of instructions squashed after a taken branch/jump (0..15). 0 disables squashing.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/WB buffer holds a real instruction this cycle.
- in_ctrl_regwrt  in  1  instruction writes rd.
- in_ctrl_branch  in  1  conditional branch.
- in_ctrl_btype  in  1  branch condition select: 0 = zero flag, 1 = negative flag.
- in_ctrl_jump  in  1  unconditional jump.
- in_ctrl_memtoreg  in  1  writeback source: 1 = memdata, 0 = aluresult.
- in_ctrl_neg  in  1  ALU negative flag.
- in_ctrl_zero  in  1  ALU zero flag.
- in_memdata  in  DATA_W  load data.
- in_aluresult  in  DATA_W  ALU result; also the branch/jump target.
- in_rd  in  6  destination register.
- rs_addr  in  6  read port A address.
- rt_addr  in  6  read port B address.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- out_pc_load  out  1  one-cycle redirect pulse to the fetch stage.
- out_pc_target  out  DATA_W  redirect target; meaningful only while out_pc_load=1.
- out_flush  out  1  squash window active.
- out_wb_valid  out  1  a write committed on the previous edge.
- out_wb_rd  out  6  register written on the previous edge.
- out_wb_data  out  DATA_W  data written on the previous edge.

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0; flush counter cleared to 0.
  - out_pc_load=0, out_pc_target=0, out_wb_valid=0, out_wb_rd=0, out_wb_data=0.
  - Reset mid-flush aborts the flush.
- Squash condition: squash = (flush counter != 0). out_flush = squash.
- Writeback data: wbdata = in_ctrl_memtoreg ? in_memdata : in_aluresult.
- Write enable: we = in_valid & in_ctrl_regwrt & ~squash.
  - On a clk edge with we=1, reg[in_rd] <= wbdata.
  - Every register, including r0, is writable.
- Taken decision: taken = in_valid & ~squash & (in_ctrl_jump | (in_ctrl_branch & (in_ctrl_btype ? in_ctrl_neg : in_ctrl_zero))).
  - Jump takes priority; flags are ignored when jump=1.
  - branch=1 with jump=1 is taken unconditionally.
- Redirect (latency 1):
  - Edge with taken=1: out_pc_load <= 1, out_pc_target <= in_aluresult.
  - Otherwise out_pc_load <= 0 and out_pc_target holds its value.
- Flush counter:
  - Edge with taken=1: counter <= FLUSH_CYCLES.
  - Else if counter != 0: counter decrements by 1.
  - A taken instruction with regwrt=1 also writes (link-style); the same-cycle write is not squashed.
  - Instructions arriving while squash=1 produce no write, no redirect and no counter reload.
- Commit echo (registered, 1 cycle):
  - out_wb_valid <= we.
  - out_wb_rd and out_wb_data update only when we=1; otherwise they hold.
- Read ports: combinational, write-first bypass.
  - rs_data = (we & in_rd == rs_addr) ? wbdata : reg[rs_addr]. rt_data uses the same rule.
  - Both ports may address the same register simultaneously.
- in_valid=0: no write, no redirect; the counter still decrements.

Test Plan:
- Reset released; write r5 = 0x0_0000_1234 (regwrt=1, memtoreg=0) -> next cycle out_wb_valid=1, out_wb_rd=5; rs_addr=5 then reads 0x1234.
- Same cycle: rd=7 write of memdata 0xABC (memtoreg=1), rs_addr=rt_addr=7 -> rs_data=rt_data=0xABC combinationally, before the edge.
- Branch with btype=0, zero=1, aluresult=0x40, FLUSH_CYCLES=3 -> out_pc_load=1 for exactly 1 cycle with target 0x40. out_flush high 3 cycles. Three regwrt instructions fed during flush leave the register file unchanged; the 4th commits.
- Branch with btype=1, neg=0, zero=1 -> not taken: no pc_load, no flush. Then jump=1 with neg=zero=0 -> taken.
- Jump with regwrt=1, rd=63 -> r63 written and redirect issued in the same cycle.
- Assert rst asynchronously at the 2nd flush cycle -> out_flush=0 and all outputs 0 immediately. After release, the next instruction commits normally.

Source files
------------

// File: rtl/wb_stage_if.sv
// EX/WB buffer fields, decode read ports and writeback-stage outputs bundled together.
interface wb_stage_if #(
  parameter int DATA_W = 33
);
  logic              in_valid;
  logic              in_ctrl_regwrt;
  logic              in_ctrl_branch;
  logic              in_ctrl_btype;
  logic              in_ctrl_jump;
  logic              in_ctrl_memtoreg;
  logic              in_ctrl_neg;
  logic              in_ctrl_zero;
  logic [DATA_W-1:0] in_memdata;
  logic [DATA_W-1:0] in_aluresult;
  logic [5:0]        in_rd;
  logic [5:0]        rs_addr;
  logic [5:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              out_pc_load;
  logic [DATA_W-1:0] out_pc_target;
  logic              out_flush;
  logic              out_wb_valid;
  logic [5:0]        out_wb_rd;
  logic [DATA_W-1:0] out_wb_data;

  modport master (
    output in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
           in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero, in_memdata, in_aluresult,
           in_rd, rs_addr, rt_addr,
    input  rs_data, rt_data, out_pc_load, out_pc_target, out_flush,
           out_wb_valid, out_wb_rd, out_wb_data
  );

  modport slave (
    input  in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
           in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero, in_memdata, in_aluresult,
           in_rd, rs_addr, rt_addr,
    output rs_data, rt_data, out_pc_load, out_pc_target, out_flush,
           out_wb_valid, out_wb_rd, out_wb_data
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: register file commit, branch/jump resolution with registered
// PC redirect, and a fixed-length squash window after each taken redirect.
module wb_stage #(
  parameter int DATA_W       = 33,
  parameter int NREGS        = 64,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [3:0]        cnt_q, cnt_d;
  logic              pc_load_q, pc_load_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic              wb_valid_q, wb_valid_d;
  logic [5:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              squash, we, taken, cond;
  logic [DATA_W-1:0] wbdata;

  assign squash = (cnt_q != 4'd0);
  assign wbdata = bus.in_ctrl_memtoreg ? bus.in_memdata : bus.in_aluresult;
  assign we     = bus.in_valid & bus.in_ctrl_regwrt & ~squash;
  assign cond   = bus.in_ctrl_btype ? bus.in_ctrl_neg : bus.in_ctrl_zero;
  assign taken  = bus.in_valid & ~squash & (bus.in_ctrl_jump | (bus.in_ctrl_branch & cond));

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[bus.in_rd] = wbdata;

    pc_load_d   = taken;
    pc_target_d = taken ? bus.in_aluresult : pc_target_q;

    // A taken redirect reloads the window; otherwise it drains by one per cycle.
    cnt_d = cnt_q;
    if (taken)       cnt_d = 4'(FLUSH_CYCLES);
    else if (squash) cnt_d = cnt_q - 4'd1;

    wb_valid_d = we;
    wb_rd_d    = we ? bus.in_rd : wb_rd_q;
    wb_data_d  = we ? wbdata    : wb_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      cnt_q       <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      regs_q      <= regs_d;
      cnt_q       <= cnt_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Write-first bypass so decode sees a value being committed this same cycle.
  assign bus.rs_data = (we && bus.in_rd == bus.rs_addr) ? wbdata : regs_q[bus.rs_addr];
  assign bus.rt_data = (we && bus.in_rd == bus.rt_addr) ? wbdata : regs_q[bus.rt_addr];

  assign bus.out_pc_load   = pc_load_q;
  assign bus.out_pc_target = pc_target_q;
  assign bus.out_flush     = squash;
  assign bus.out_wb_valid  = wb_valid_q;
  assign bus.out_wb_rd     = wb_rd_q;
  assign bus.out_wb_data   = wb_data_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commit, bypass, branch/jump redirect, squash, async reset.
module tb_wb_stage;
  localparam int DW = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  wb_stage_if #(.DATA_W(DW)) bus ();

  wb_stage #(.DATA_W(DW), .NREGS(64), .FLUSH_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_ctrl_regwrt = 0; bus.in_ctrl_branch = 0;
    bus.in_ctrl_btype = 0; bus.in_ctrl_jump = 0; bus.in_ctrl_memtoreg = 0;
    bus.in_ctrl_neg = 0; bus.in_ctrl_zero = 0;
    bus.in_memdata = '0; bus.in_aluresult = '0; bus.in_rd = '0;
  endtask

  task automatic instr(input logic regwrt, branch, btype, jump, memtoreg, neg, zero,
                       input logic [DW-1:0] mem, alu, input logic [5:0] rd);
    bus.in_valid = 1; bus.in_ctrl_regwrt = regwrt; bus.in_ctrl_branch = branch;
    bus.in_ctrl_btype = btype; bus.in_ctrl_jump = jump; bus.in_ctrl_memtoreg = memtoreg;
    bus.in_ctrl_neg = neg; bus.in_ctrl_zero = zero;
    bus.in_memdata = mem; bus.in_aluresult = alu; bus.in_rd = rd;
  endtask

  task automatic test_reset();
    idle();
    bus.rs_addr = 6'd5; bus.rt_addr = 6'd0;
    tick(); tick();
    checks++; if (bus.out_pc_load !== 1'b0) begin errs++; $display("FAIL reset_pc_load got %b exp 0", bus.out_pc_load); end
    checks++; if (bus.out_pc_target !== '0) begin errs++; $display("FAIL reset_pc_target got %h exp 0", bus.out_pc_target); end
    checks++; if (bus.out_flush !== 1'b0) begin errs++; $display("FAIL reset_flush got %b exp 0", bus.out_flush); end
    checks++; if (bus.out_wb_valid !== 1'b0 || bus.out_wb_rd !== 6'd0 || bus.out_wb_data !== '0)
      begin errs++; $display("FAIL reset_wb got v=%b rd=%0d d=%h exp 0", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
    checks++; if (bus.rs_data !== '0) begin errs++; $display("FAIL reset_rs_data got %h exp 0", bus.rs_data); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_write();
    instr(1, 0, 0, 0, 0, 0, 0, 33'h0, 33'h1234, 6'd5);
    tick();
    checks++; if (bus.out_wb_valid !== 1'b1 || bus.out_wb_rd !== 6'd5 || bus.out_wb_data !== 33'h1234)
      begin errs++; $display("FAIL write_echo got v=%b rd=%0d d=%h exp 1/5/1234", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
    idle(); bus.rs_addr = 6'd5; #1;
    checks++; if (bus.rs_data !== 33'h1234) begin errs++; $display("FAIL write_read got %h exp 1234", bus.rs_data); end
    tick();
    checks++; if (bus.out_wb_valid !== 1'b0 || bus.out_wb_rd !== 6'd5 || bus.out_wb_data !== 33'h1234)
      begin errs++; $display("FAIL write_hold got v=%b rd=%0d d=%h exp 0/5/1234", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
  endtask

  task automatic test_bypass();
    instr(1, 0, 0, 0, 1, 0, 0, 33'hABC, 33'h777, 6'd7);
    bus.rs_addr = 6'd7; bus.rt_addr = 6'd7; #1;
    checks++; if (bus.rs_data !== 33'hABC || bus.rt_data !== 33'hABC)
      begin errs++; $display("FAIL bypass got rs=%h rt=%h exp abc", bus.rs_data, bus.rt_data); end
    tick();
    idle(); #1;
    checks++; if (bus.rs_data !== 33'hABC || bus.rt_data !== 33'hABC)
      begin errs++; $display("FAIL bypass_stored got rs=%h rt=%h exp abc", bus.rs_data, bus.rt_data); end
  endtask

  task automatic test_branch_flush();
    instr(0, 1, 0, 0, 0, 0, 1, 33'h0, 33'h40, 6'd0);
    tick();
    checks++; if (bus.out_pc_load !== 1'b1 || bus.out_pc_target !== 33'h40)
      begin errs++; $display("FAIL br_redirect got load=%b tgt=%h exp 1/40", bus.out_pc_load, bus.out_pc_target); end
    checks++; if (bus.out_flush !== 1'b1) begin errs++; $display("FAIL br_flush1 got %b exp 1", bus.out_flush); end
    instr(1, 0, 0, 0, 0, 0, 0, 33'h0, 33'h111, 6'd10);
    bus.rs_addr = 6'd10; #1;
    checks++; if (bus.rs_data !== '0) begin errs++; $display("FAIL br_no_bypass got %h exp 0", bus.rs_data); end
    tick();
    checks++; if (bus.out_pc_load !== 1'b0 || bus.out_flush !== 1'b1 || bus.out_wb_valid !== 1'b0)
      begin errs++; $display("FAIL br_flush2 got load=%b flush=%b wbv=%b exp 0/1/0", bus.out_pc_load, bus.out_flush, bus.out_wb_valid); end
    instr(1, 1, 0, 1, 0, 0, 1, 33'h0, 33'h222, 6'd11);
    tick();
    checks++; if (bus.out_pc_load !== 1'b0 || bus.out_flush !== 1'b1)
      begin errs++; $display("FAIL br_flush3 got load=%b flush=%b exp 0/1", bus.out_pc_load, bus.out_flush); end
    instr(1, 0, 0, 0, 0, 0, 0, 33'h0, 33'h333, 6'd12);
    tick();
    checks++; if (bus.out_flush !== 1'b0 || bus.out_wb_valid !== 1'b0 || bus.out_pc_load !== 1'b0)
      begin errs++; $display("FAIL br_window_end got flush=%b wbv=%b load=%b exp 0/0/0", bus.out_flush, bus.out_wb_valid, bus.out_pc_load); end
    instr(1, 0, 0, 0, 0, 0, 0, 33'h0, 33'h444, 6'd13);
    bus.rs_addr = 6'd10; bus.rt_addr = 6'd11;
    tick();
    checks++; if (bus.out_wb_valid !== 1'b1 || bus.out_wb_rd !== 6'd13 || bus.out_wb_data !== 33'h444)
      begin errs++; $display("FAIL br_4th_commit got v=%b rd=%0d d=%h exp 1/13/444", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
    idle(); #1;
    checks++; if (bus.rs_data !== '0 || bus.rt_data !== '0)
      begin errs++; $display("FAIL br_squashed_regs got r10=%h r11=%h exp 0", bus.rs_data, bus.rt_data); end
    bus.rs_addr = 6'd12; bus.rt_addr = 6'd13; #1;
    checks++; if (bus.rs_data !== '0 || bus.rt_data !== 33'h444)
      begin errs++; $display("FAIL br_regs got r12=%h r13=%h exp 0/444", bus.rs_data, bus.rt_data); end
  endtask

  task automatic test_not_taken();
    instr(0, 1, 1, 0, 0, 0, 1, 33'h0, 33'h50, 6'd0);
    tick();
    checks++; if (bus.out_pc_load !== 1'b0 || bus.out_flush !== 1'b0 || bus.out_pc_target !== 33'h40)
      begin errs++; $display("FAIL nt_branch got load=%b flush=%b tgt=%h exp 0/0/40", bus.out_pc_load, bus.out_flush, bus.out_pc_target); end
    instr(0, 0, 0, 1, 0, 0, 0, 33'h0, 33'h99, 6'd0);
    tick();
    checks++; if (bus.out_pc_load !== 1'b1 || bus.out_pc_target !== 33'h99 || bus.out_flush !== 1'b1)
      begin errs++; $display("FAIL jump_taken got load=%b tgt=%h flush=%b exp 1/99/1", bus.out_pc_load, bus.out_pc_target, bus.out_flush); end
    idle();
    tick(); tick(); tick();
    checks++; if (bus.out_flush !== 1'b0 || bus.out_pc_target !== 33'h99)
      begin errs++; $display("FAIL jump_drain got flush=%b tgt=%h exp 0/99", bus.out_flush, bus.out_pc_target); end
  endtask

  task automatic test_jump_link();
    instr(1, 0, 0, 1, 0, 0, 0, 33'h0, 33'h1_0000_0080, 6'd63);
    bus.rs_addr = 6'd63; #1;
    checks++; if (bus.rs_data !== 33'h1_0000_0080) begin errs++; $display("FAIL link_bypass got %h exp 100000080", bus.rs_data); end
    tick();
    checks++; if (bus.out_pc_load !== 1'b1 || bus.out_pc_target !== 33'h1_0000_0080)
      begin errs++; $display("FAIL link_redirect got load=%b tgt=%h exp 1/100000080", bus.out_pc_load, bus.out_pc_target); end
    checks++; if (bus.out_wb_valid !== 1'b1 || bus.out_wb_rd !== 6'd63 || bus.out_wb_data !== 33'h1_0000_0080)
      begin errs++; $display("FAIL link_commit got v=%b rd=%0d d=%h exp 1/63/100000080", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
    idle(); #1;
    checks++; if (bus.rs_data !== 33'h1_0000_0080) begin errs++; $display("FAIL link_r63 got %h exp 100000080", bus.rs_data); end
    tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    instr(0, 1, 0, 0, 0, 0, 1, 33'h0, 33'h200, 6'd0);
    tick();
    idle();
    tick();
    checks++; if (bus.out_flush !== 1'b1) begin errs++; $display("FAIL ar_pre_flush got %b exp 1", bus.out_flush); end
    #2 rst = 1;
    #1;
    checks++; if (bus.out_flush !== 1'b0 || bus.out_pc_load !== 1'b0 || bus.out_pc_target !== '0)
      begin errs++; $display("FAIL ar_pc got flush=%b load=%b tgt=%h exp 0", bus.out_flush, bus.out_pc_load, bus.out_pc_target); end
    checks++; if (bus.out_wb_valid !== 1'b0 || bus.out_wb_rd !== 6'd0 || bus.out_wb_data !== '0)
      begin errs++; $display("FAIL ar_wb got v=%b rd=%0d d=%h exp 0", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data); end
    bus.rs_addr = 6'd63; bus.rt_addr = 6'd13; #1;
    checks++; if (bus.rs_data !== '0 || bus.rt_data !== '0)
      begin errs++; $display("FAIL ar_regs got r63=%h r13=%h exp 0", bus.rs_data, bus.rt_data); end
    @(negedge clk); rst = 0;
    instr(1, 0, 0, 0, 1, 0, 0, 33'h55, 33'h0, 6'd20);
    tick();
    checks++; if (bus.out_wb_valid !== 1'b1 || bus.out_wb_rd !== 6'd20 || bus.out_wb_data !== 33'h55 || bus.out_flush !== 1'b0)
      begin errs++; $display("FAIL ar_after got v=%b rd=%0d d=%h flush=%b exp 1/20/55/0", bus.out_wb_valid, bus.out_wb_rd, bus.out_wb_data, bus.out_flush); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_branch_flush();
    test_not_taken();
    test_jump_link();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
